// File: rtl/trng_sample_ctrl_if.sv
// Handshake/bus bundle between the TRNG sampling controller, the ring cells and the register/FIFO side.
// master = controller, slave = the ring cells plus the consumer.
interface trng_sample_ctrl_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic              stop;
    logic              ro_bit;
    logic              ro_en;
    logic [1:0]        ro_sel;
    logic [WORD_W-1:0] rdata;
    logic              rvalid;
    logic              rready;
    logic              busy;
    logic              health_fail;

    modport master (
        input  start, stop, ro_bit, rready,
        output ro_en, ro_sel, rdata, rvalid, busy, health_fail
    );

    modport slave (
        output start, stop, ro_bit, rready,
        input  ro_en, ro_sel, rdata, rvalid, busy, health_fail
    );
endinterface

// File: rtl/trng_sample_ctrl.sv
// Ring-oscillator TRNG sequencer: warm-up, decimated sampling, repetition-count health test; word out WARMUP+WORD_W*SAMPLE_DIV clocks after start.
// Backpressure: a completed word is held in HOLD (sampling paused, ring still enabled) until rvalid&rready.
module trng_sample_ctrl #(
    parameter int WORD_W        = 32,
    parameter int WARMUP_CYCLES = 64,
    parameter int SAMPLE_DIV    = 8,
    parameter int REP_LIMIT     = 16
) (
    input logic                clocked_on,
    input logic                preset,
    trng_sample_ctrl_if.master bus
);

    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int BIT_W  = $clog2(WORD_W + 1);
    localparam int REP_W  = $clog2(REP_LIMIT + 1);

    localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);
    localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_SAMPLE,
        S_HOLD,
        S_FAIL
    } state_t;

    state_t state, state_nxt;

    logic              ro_meta, ro_s;
    logic [WARM_W-1:0] warm_cnt, warm_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [REP_W-1:0]  rep_cnt, rep_nxt, rep_calc;
    logic              prev_bit, prev_nxt;
    logic [WORD_W-1:0] shift_q, shift_nxt;
    logic [WORD_W-1:0] rdata_q, rdata_nxt;
    logic              rvalid_q, rvalid_nxt;
    logic [1:0]        sel_q, sel_nxt;
    logic              ro_en_q, ro_en_nxt;
    logic              busy_q, busy_nxt;
    logic              fail_q, fail_nxt;

    // ro_bit is asynchronous to clocked_on; only the second flop feeds logic.
    always_ff @(posedge clocked_on or posedge preset) begin
        if (preset) begin
            ro_meta <= 1'b0;
            ro_s    <= 1'b0;
        end else begin
            ro_meta <= bus.ro_bit;
            ro_s    <= ro_meta;
        end
    end

    always_ff @(posedge clocked_on or posedge preset) begin
        if (preset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        warm_nxt   = warm_cnt;
        div_nxt    = div_cnt;
        bit_nxt    = bit_cnt;
        rep_nxt    = rep_cnt;
        rep_calc   = '0;
        prev_nxt   = prev_bit;
        shift_nxt  = shift_q;
        rdata_nxt  = rdata_q;
        rvalid_nxt = rvalid_q;
        sel_nxt    = sel_q;

        case (state)
            S_IDLE: begin
                rvalid_nxt = 1'b0;
                if (bus.start && !bus.stop) begin
                    state_nxt = S_WARMUP;
                    warm_nxt  = WARM_LOAD;
                end
            end

            S_WARMUP: begin
                if (bus.stop) begin
                    state_nxt = S_IDLE;
                end else if (warm_cnt == '0) begin
                    state_nxt = S_SAMPLE;
                    div_nxt   = '0;
                    bit_nxt   = '0;
                    rep_nxt   = '0;
                end else begin
                    warm_nxt = warm_cnt - 1'b1;
                end
            end

            S_SAMPLE: begin
                if (bus.stop) begin
                    state_nxt = S_IDLE;
                end else if (div_cnt == DIV_LAST) begin
                    div_nxt   = '0;
                    shift_nxt = {shift_q[WORD_W-2:0], ro_s};
                    bit_nxt   = bit_cnt + 1'b1;
                    prev_nxt  = ro_s;
                    // rep_cnt == 0 marks the first sample since (re)entering SAMPLE
                    if (rep_cnt == '0 || ro_s != prev_bit) begin
                        rep_calc = REP_ONE;
                    end else begin
                        rep_calc = rep_cnt + 1'b1;
                    end
                    rep_nxt = rep_calc;
                    if (rep_calc == REP_MAX) begin
                        state_nxt = S_FAIL;
                    end else if (bit_cnt == BIT_LAST) begin
                        rdata_nxt  = shift_nxt;
                        rvalid_nxt = 1'b1;
                        state_nxt  = S_HOLD;
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end

            S_HOLD: begin
                if (bus.stop) begin
                    state_nxt  = S_IDLE;
                    rvalid_nxt = 1'b0;
                end else if (rvalid_q && bus.rready) begin
                    state_nxt  = S_SAMPLE;
                    rvalid_nxt = 1'b0;
                    sel_nxt    = sel_q + 2'd1;
                    div_nxt    = '0;
                    bit_nxt    = '0;
                    rep_nxt    = '0;
                end
            end

            S_FAIL: begin
                rvalid_nxt = 1'b0;
            end

            default: begin
                state_nxt  = S_IDLE;
                rvalid_nxt = 1'b0;
            end
        endcase

        busy_nxt  = (state_nxt == S_WARMUP) || (state_nxt == S_SAMPLE) || (state_nxt == S_HOLD);
        ro_en_nxt = busy_nxt;
        fail_nxt  = (state_nxt == S_FAIL);
    end

    always_ff @(posedge clocked_on or posedge preset) begin
        if (preset) begin
            warm_cnt <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            rep_cnt  <= '0;
            prev_bit <= 1'b0;
            shift_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            sel_q    <= 2'd0;
            ro_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            warm_cnt <= warm_nxt;
            div_cnt  <= div_nxt;
            bit_cnt  <= bit_nxt;
            rep_cnt  <= rep_nxt;
            prev_bit <= prev_nxt;
            shift_q  <= shift_nxt;
            rdata_q  <= rdata_nxt;
            rvalid_q <= rvalid_nxt;
            sel_q    <= sel_nxt;
            ro_en_q  <= ro_en_nxt;
            busy_q   <= busy_nxt;
            fail_q   <= fail_nxt;
        end
    end

    assign bus.ro_en       = ro_en_q;
    assign bus.ro_sel      = sel_q;
    assign bus.rdata       = rdata_q;
    assign bus.rvalid      = rvalid_q;
    assign bus.busy        = busy_q;
    assign bus.health_fail = fail_q;

endmodule
